// File: rtl/jk_reg_bank.sv
// Bank of WIDTH independent JK flip-flops with a parallel load, per-bit edge pulses and an optional change counter.
// The change counter is built only when JK_REG_BANK_CHG_CNT_EN is defined; otherwise chg_cnt reads 0.
module jk_reg_bank #(
  parameter int WIDTH        = 8,
  parameter int CNT_W        = 8,
  parameter int TOGGLE_ON_11 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [CNT_W-1:0] chg_cnt
);

  logic [WIDTH-1:0] next_q;

  always_comb begin
    next_q = q;
    if (load) begin
      next_q = d;
    end else if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case ({j[i], k[i]})
          2'b00: next_q[i] = q[i];
          2'b01: next_q[i] = 1'b0;
          2'b10: next_q[i] = 1'b1;
          2'b11: next_q[i] = (TOGGLE_ON_11 != 0) ? ~q[i] : q[i];
          default: next_q[i] = q[i];
        endcase
      end
    end
  end

  // Edge pulses are computed from the same next_q that updates q, so they line up with the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      q    <= next_q;
      rise <= next_q & ~q;
      fall <= ~next_q & q;
    end
  end

`ifdef JK_REG_BANK_CHG_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Any number of bits changing on one edge counts once; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((next_q != q) && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign chg_cnt = cnt;
`else
  assign chg_cnt = '0;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed vector bench for jk_reg_bank: a toggling instance, a holding (TOGGLE_ON_11=0) instance and a 2-bit counter instance.
module tb_jk_reg_bank;

`ifdef JK_REG_BANK_CHG_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [7:0] d, j, k;

  logic [7:0] q_a, rise_a, fall_a, cnt_a;
  logic [7:0] q_h, rise_h, fall_h, cnt_h;
  logic [7:0] q_s, rise_s, fall_s;
  logic [1:0] cnt_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(8), .CNT_W(8), .TOGGLE_ON_11(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .j(j), .k(k),
    .q(q_a), .rise(rise_a), .fall(fall_a), .chg_cnt(cnt_a));

  jk_reg_bank #(.WIDTH(8), .CNT_W(8), .TOGGLE_ON_11(0)) u_hold (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .j(j), .k(k),
    .q(q_h), .rise(rise_h), .fall(fall_h), .chg_cnt(cnt_h));

  jk_reg_bank #(.WIDTH(8), .CNT_W(2), .TOGGLE_ON_11(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .j(j), .k(k),
    .q(q_s), .rise(rise_s), .fall(fall_s), .chg_cnt(cnt_s));

  typedef struct {
    logic       rst, en, load;
    logic [7:0] d, j, k;
    logic [7:0] q, rise, fall, cnt;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic l,
                       input logic [7:0] dd, input logic [7:0] jj, input logic [7:0] kk);
    rst = r; en = e; load = l; d = dd; j = jj; k = kk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rst  en   ld   d      j      k      q      rise   fall   cnt
    vecs[0]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'd0};
    vecs[1]  = '{1'b1,1'b1,1'b1,8'hAA,8'hFF,8'h00,8'h00,8'h00,8'h00,8'd0};
    vecs[2]  = '{1'b0,1'b1,1'b0,8'h00,8'hFF,8'h00,8'hFF,8'hFF,8'h00,8'd1};
    vecs[3]  = '{1'b0,1'b1,1'b0,8'h00,8'hFF,8'h00,8'hFF,8'h00,8'h00,8'd1};
    vecs[4]  = '{1'b0,1'b0,1'b1,8'hA5,8'h00,8'h00,8'hA5,8'h00,8'h5A,8'd2};
    vecs[5]  = '{1'b0,1'b1,1'b0,8'h00,8'hFF,8'hFF,8'h5A,8'h5A,8'hA5,8'd3};
    vecs[6]  = '{1'b0,1'b0,1'b1,8'h5A,8'h00,8'h00,8'h5A,8'h00,8'h00,8'd3};
    vecs[7]  = '{1'b0,1'b1,1'b1,8'h3C,8'hFF,8'h00,8'h3C,8'h24,8'h42,8'd4};
    vecs[8]  = '{1'b0,1'b0,1'b0,8'h00,8'hFF,8'hFF,8'h3C,8'h00,8'h00,8'd4};
    vecs[9]  = '{1'b0,1'b0,1'b0,8'h00,8'hFF,8'h00,8'h3C,8'h00,8'h00,8'd4};
    vecs[10] = '{1'b0,1'b0,1'b0,8'h00,8'h00,8'hFF,8'h3C,8'h00,8'h00,8'd4};
    vecs[11] = '{1'b0,1'b1,1'b0,8'h00,8'h0F,8'hF0,8'h0F,8'h03,8'h30,8'd5};
    vecs[12] = '{1'b0,1'b1,1'b0,8'h00,8'h00,8'h00,8'h0F,8'h00,8'h00,8'd5};
    vecs[13] = '{1'b0,1'b1,1'b0,8'h00,8'h05,8'h0A,8'h05,8'h00,8'h0A,8'd6};
    vecs[14] = '{1'b1,1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'd0};
    vecs[15] = '{1'b0,1'b0,1'b1,8'h0F,8'h00,8'h00,8'h0F,8'h0F,8'h00,8'd1};
    vecs[16] = '{1'b0,1'b0,1'b1,8'hFF,8'h00,8'h00,8'hFF,8'hF0,8'h00,8'd2};
    // reset on the same edge as a load wins and produces no fall pulse
    vecs[17] = '{1'b1,1'b1,1'b1,8'h0F,8'hFF,8'h00,8'h00,8'h00,8'h00,8'd0};
    vecs[18] = '{1'b0,1'b1,1'b1,8'h81,8'h00,8'hFF,8'h81,8'h81,8'h00,8'd1};

    rst = 1'b1; en = 1'b0; load = 1'b0; d = '0; j = '0; k = '0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].d, vecs[i].j, vecs[i].k);
      chk($sformatf("v%0d.q", i),    q_a,    vecs[i].q);
      chk($sformatf("v%0d.rise", i), rise_a, vecs[i].rise);
      chk($sformatf("v%0d.fall", i), fall_a, vecs[i].fall);
      chk($sformatf("v%0d.cnt", i),  cnt_a,  CNT_ON ? vecs[i].cnt : 8'd0);
    end

    // JK=11 with TOGGLE_ON_11=0 holds
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'hA5, 8'h00, 8'h00);
    chk("hold.load_q", q_h, 8'hA5);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF);
    chk("hold.q",    q_h,    8'hA5);
    chk("hold.rise", rise_h, 8'h00);
    chk("hold.fall", fall_h, 8'h00);
    chk("hold.cnt",  cnt_h,  CNT_ON ? 8'd1 : 8'd0);
    chk("tog.q",     q_a,    8'h5A);

    // 2-bit counter saturates at 3
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("sat.rst_cnt", cnt_s, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 8'h01);
      chk($sformatf("sat.q%0d", i),   q_s,   {7'd0, i[0]});
      chk($sformatf("sat.cnt%0d", i), cnt_s, CNT_ON ? ((i < 3) ? i[1:0] : 2'd3) : 2'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of independent JK bits, at least 1.
REQ-002 Parameter CNT_W, default 8: width of the change counter, at least 2.
REQ-003 Parameter TOGGLE_ON_11, default 1: 1 means JK=11 toggles; 0 means JK=11 holds.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port en  input  1  JK update enable; 0 means all bits hold.
REQ-007 Port load  input  1  synchronous parallel load of d into q.
REQ-008 Port d  input  WIDTH  parallel load data.
REQ-009 Port j  input  WIDTH  per-bit J.
REQ-010 Port k  input  WIDTH  per-bit K.
REQ-011 Port q  output  WIDTH  registered state.
REQ-012 Port rise  output  WIDTH  registered per-bit 0->1 pulse, aligned with the new q.
REQ-013 Port fall  output  WIDTH  registered per-bit 1->0 pulse, aligned with the new q.
REQ-014 Port chg_cnt  output  CNT_W  saturating count of edges on which q changed.

Function
REQ-015 Next-state priority SHALL be: rst, then load, then en, then hold.
REQ-016 When load=1, the next q SHALL be d, regardless of j, k and en.
REQ-017 When load=0 and en=1, each bit i SHALL update independently: JK=00 hold, JK=01 clear, JK=10 set, JK=11 toggle if TOGGLE_ON_11=1, else hold.
REQ-018 When load=0 and en=0, q SHALL hold regardless of j and k.
REQ-019 q SHALL update on the same rising edge that samples the controls (one-edge latency, no combinational path from inputs to q).
REQ-020 On each non-reset edge, rise SHALL become next_q & ~q and fall SHALL become ~next_q & q; each pulse lasts exactly one cycle unless the bit changes again.
REQ-021 chg_cnt SHALL increment by 1 on each non-reset edge where next_q != q.
REQ-022 chg_cnt SHALL saturate at 2^CNT_W-1, with no wrap.
REQ-023 A load whose d equals the current q SHALL produce no rise or fall and no chg_cnt increment.
REQ-024 Several bits changing on the same edge SHALL count as one change in chg_cnt.

Reset
REQ-025 While rst=1 at a rising edge, q, rise, fall and chg_cnt SHALL all be set to 0, overriding load and en.
REQ-026 Reset asserted mid-operation SHALL take effect on the next edge, with no rise or fall generated by the reset itself.
REQ-027 On the first edge after rst deasserts, normal priority SHALL apply.

Configuration
REQ-028 Macro JK_REG_BANK_CHG_CNT_EN SHALL control the change counter.
REQ-029 With JK_REG_BANK_CHG_CNT_EN defined, the counter SHALL be implemented as specified in REQ-021 to REQ-024.
REQ-030 Without JK_REG_BANK_CHG_CNT_EN, chg_cnt SHALL be tied to 0, no counter logic is built, and all other behaviour is unchanged.

Verification
REQ-031 WIDTH=8: rst=1 for 2 edges, then en=1, j=8'hFF, k=8'h00 -> q=8'hFF, rise=8'hFF for 1 cycle, chg_cnt=1.
REQ-032 q=8'hA5, en=1, j=k=8'hFF, TOGGLE_ON_11=1 -> q=8'h5A, rise=8'h5A, fall=8'hA5; with TOGGLE_ON_11=0 -> q stays 8'hA5, rise=fall=0.
REQ-033 Same edge: load=1, d=8'h3C, en=1, j=8'hFF, k=8'h00 -> q=8'h3C (load wins); then en=0 with any j/k for 3 edges -> q holds 8'h3C and chg_cnt is unchanged.
REQ-034 CNT_W=2, toggle bit 0 on 5 consecutive edges -> chg_cnt reads 1, 2, 3, 3, 3 (saturation).
REQ-035 q=8'hFF, chg_cnt=2, assert rst on the same edge as load=1, d=8'h0F -> q=0, rise=fall=0, chg_cnt=0.
REQ-036 Build without JK_REG_BANK_CHG_CNT_EN and rerun REQ-031 -> q and rise as before, chg_cnt remains 0 throughout.
